ttlock_key_loader: RTL and testbench

- Sequential key-provisioning controller that drives the 32-bit keyinput bus of a TTLock-locked netlist.
- Accepts the secret key as a serial bit stream over a valid/ready handshake and assembles it in a shadow register.
- Presents the key to the locked core only after a complete load (optional parity check) is committed; unlock/key-update sequences in simulation are driven through this block.

---
 rtl/ttlock_key_loader.sv | 183 ++++++++++++++++++
 tb/tb_ttlock_key_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttlock_key_loader.sv
// ttlock_key_loader: serial key-provisioning controller for a TTLock-locked core.
// Key bits arrive LSB first over a valid/ready handshake. They are assembled in a
// shadow register and appear on key_out only when a complete load commits.
// Optional feature macro: KEY_PARITY_EN (adds one even-parity beat after the key).
module ttlock_key_loader #(
    parameter int KEY_WIDTH    = 32,
    parameter int LOAD_TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             clear,
    input  logic                             bit_valid,
    input  logic                             bit_data,
    output logic                             bit_ready,
    output logic [KEY_WIDTH-1:0]             key_out,
    output logic                             key_applied,
    output logic                             busy,
    output logic                             err,
    output logic [$clog2(KEY_WIDTH+1)-1:0]   bit_count
);

    localparam int CNT_W = $clog2(KEY_WIDTH + 1);
    localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_COMMIT,
        ST_ERROR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [KEY_WIDTH-1:0] shadow;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 load_start;
    logic                 shift_bit;
    logic                 beat_done;
    logic                 tmo_tick;
    logic                 commit;
    logic                 timed_out;

`ifdef KEY_PARITY_EN
    // Even parity: the key bits together with the parity bit must XOR to zero.
    function automatic logic parity_ok(input logic [KEY_WIDTH-1:0] key, input logic pbit);
        return ~((^key) ^ pbit);
    endfunction
`endif

    // This stall cycle is the LOAD_TIMEOUT-th in a row, so the load aborts at this edge.
    assign timed_out = (tmo_cnt == TMO_W'(LOAD_TIMEOUT - 1));

    // Next-state logic and state-decoded outputs; clear overrides every other action.
    always_comb begin
        state_next = state;
        bit_ready  = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        load_start = 1'b0;
        shift_bit  = 1'b0;
        beat_done  = 1'b0;
        tmo_tick   = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    shift_bit = 1'b1;
                    if (bit_count == CNT_W'(KEY_WIDTH - 1)) begin
`ifdef KEY_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_COMMIT;
`endif
                    end
                end else begin
                    tmo_tick = 1'b1;
                    if (timed_out) begin
                        state_next = ST_ERROR;
                    end
                end
            end
`ifdef KEY_PARITY_EN
            ST_PARITY: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    beat_done  = 1'b1;
                    state_next = parity_ok(shadow, bit_data) ? ST_COMMIT : ST_ERROR;
                end else begin
                    tmo_tick = 1'b1;
                    if (timed_out) begin
                        state_next = ST_ERROR;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                busy       = 1'b1;
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                err = 1'b1;
                if (start) begin
                    load_start = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            load_start = 1'b0;
            shift_bit  = 1'b0;
            beat_done  = 1'b0;
            tmo_tick   = 1'b0;
            commit     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shadow key assembly: bit k of a load lands in shadow[k]; the parity beat is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            bit_count <= '0;
        end else if (clear || load_start) begin
            shadow    <= '0;
            bit_count <= '0;
        end else if (shift_bit) begin
            shadow    <= shadow | (KEY_WIDTH'(bit_data) << bit_count);
            bit_count <= bit_count + CNT_W'(1);
        end
    end

    // Consecutive no-transfer counter while bits are being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (clear || load_start || shift_bit || beat_done) begin
            tmo_cnt <= '0;
        end else if (tmo_tick) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Key output: changes only on commit, clear or reset, so no partial key is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out     <= '0;
            key_applied <= 1'b0;
        end else if (clear) begin
            key_out     <= '0;
            key_applied <= 1'b0;
        end else if (commit) begin
            key_out     <= shadow;
            key_applied <= 1'b1;
        end else if (load_start) begin
            key_applied <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ttlock_key_loader.sv
// Self-checking bench for ttlock_key_loader: table-driven loads, hand-written
// corner sequences and randomized traffic compared against a behavioural model.
module tb_ttlock_key_loader;

    localparam int KW = 32;
    localparam int TO = 16;
    localparam int CW = $clog2(KW + 1);
`ifdef KEY_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic          bit_valid;
    logic          bit_data;
    logic          bit_ready;
    logic [KW-1:0] key_out;
    logic          key_applied;
    logic          busy;
    logic          err;
    logic [CW-1:0] bit_count;

    ttlock_key_loader #(.KEY_WIDTH(KW), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .key_out(key_out), .key_applied(key_applied), .busy(busy),
        .err(err), .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: a queue of accepted bits plus a few flags.
    logic [KW-1:0] m_key;
    bit            m_applied;
    bit            m_aborted;
    bit            m_loading;
    bit            m_commit;
    bit            m_bits[$];
    int            m_stall;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ready_cnt = 0;

    typedef struct {
        logic [KW-1:0] key;
        int            gap_max;
        int            stall_after;
        int            clear_at;
        logic [KW-1:0] exp_key;
        bit            exp_applied;
        bit            exp_err;
        int            exp_count;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [KW-1:0] m_pack();
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < m_bits.size(); i++) k[i] = m_bits[i];
        return k;
    endfunction

    task automatic model_reset();
        m_key = '0; m_applied = 0; m_aborted = 0; m_loading = 0; m_commit = 0;
        m_bits.delete(); m_stall = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit v, input bit d);
        if (c) begin
            model_reset();
        end else if (m_commit) begin
            m_key = m_pack(); m_applied = 1; m_commit = 0;
        end else if (m_loading) begin
            if (v) begin
                m_stall = 0;
                if (m_bits.size() < KW) begin
                    m_bits.push_back(d);
                    if (m_bits.size() == KW && !PAR) begin
                        m_loading = 0; m_commit = 1;
                    end
                end else begin
                    m_loading = 0;
                    if ((^m_pack()) ^ d) m_aborted = 1;
                    else m_commit = 1;
                end
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    m_loading = 0; m_aborted = 1;
                end
            end
        end else if (s) begin
            m_loading = 1; m_aborted = 0; m_applied = 0; m_bits.delete(); m_stall = 0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packed as {ready, busy, err, applied, bit_count, key_out}.
    task automatic check_model(input string name);
        check(name,
              {22'd0, bit_ready, busy, err, key_applied, bit_count, key_out},
              {22'd0, m_loading, m_loading | m_commit, m_aborted, m_applied,
               CW'(m_bits.size()), m_key});
    endtask

    // One clock: drive inputs, advance the model with them, then compare after the edge.
    task automatic cycle(input bit s, input bit c, input bit v, input bit d);
        start = s; clear = c; bit_valid = v; bit_data = d;
        if (bit_ready) ready_cnt++;
        @(posedge clk);
        model_step(s, c, v, d);
        #1;
        check_model("cycle");
        start = 0; clear = 0; bit_valid = 0;
    endtask

    task automatic load(input logic [KW-1:0] key, input int gap_max, input int stall_after,
                        input int clear_at, input bit bad_parity);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < KW; i++) begin
            if (clear_at == i) begin
                cycle(0, 1, 1, key[i]);
                return;
            end
            if (gap_max > 0)
                repeat ($urandom_range(32'(gap_max), 0)) cycle(0, 0, 0, 1'($urandom_range(1, 0)));
            cycle(0, 0, 1, key[i]);
            if (stall_after == i) begin
                repeat (TO) cycle(0, 0, 0, 0);
                return;
            end
        end
        if (PAR) cycle(0, 0, 1, (^key) ^ bad_parity);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        logic [KW-1:0] k2;
        vecs[0] = '{32'hA5C3_0F96, 0,  -1, -1, 32'hA5C3_0F96, 1, 0, 32};
        vecs[1] = '{32'hA5C3_0F96, 10, -1, -1, 32'hA5C3_0F96, 1, 0, 32};
        vecs[2] = '{32'h1234_5678, 0,  7,  -1, 32'hA5C3_0F96, 0, 1, 8};
        vecs[3] = '{32'h1234_5678, 0,  -1, 20, 32'h0000_0000, 0, 0, 0};
        vecs[4] = '{32'hFFFF_FFFF, 2,  -1, -1, 32'hFFFF_FFFF, 1, 0, 32};

        rst_n = 0; start = 0; clear = 0; bit_valid = 0; bit_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1;

        for (int i = 0; i < 5; i++) begin
            ready_cnt = 0;
            load(vecs[i].key, vecs[i].gap_max, vecs[i].stall_after, vecs[i].clear_at, 0);
            check($sformatf("row%0d_key", i), 64'(key_out), 64'(vecs[i].exp_key));
            check($sformatf("row%0d_applied", i), 64'(key_applied), 64'(vecs[i].exp_applied));
            check($sformatf("row%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("row%0d_count", i), 64'(bit_count), 64'(vecs[i].exp_count));
            check($sformatf("row%0d_busy", i), 64'(busy), 64'h0);
            if (i == 0) check("ready_cycles", 64'(ready_cnt), 64'(KW + int'(PAR)));
        end

        // start and clear together: clear wins, nothing starts
        cycle(1, 1, 0, 0);
        check("sc_busy", 64'(busy), 64'h0);
        check("sc_key", 64'(key_out), 64'h0);
        cycle(0, 0, 1, 1);
        check("idle_valid_ignored", 64'(bit_count), 64'h0);

        // asynchronous reset mid-load clears outputs before any clock edge
        load(32'h1234_5678, 0, -1, -1, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1);
        #3 rst_n = 0;
        #1;
        check("async_rst", {22'd0, bit_ready, busy, err, key_applied, bit_count, key_out}, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        check_model("rst_held");
        load(32'hFFFF_FFFF, 0, -1, -1, 0);
        check("post_rst_key", 64'(key_out), 64'hFFFF_FFFF);
        check("post_rst_applied", 64'(key_applied), 64'h1);

        // back-to-back: old key stays visible until the new one commits
        load(32'hA5C3_0F96, 0, -1, -1, 0);
        k2 = 32'h1234_5678;
        cycle(1, 0, 0, 0);
        check("b2b_applied_drop", 64'(key_applied), 64'h0);
        check("b2b_key_hold", 64'(key_out), 64'hA5C3_0F96);
        for (int i = 0; i < KW; i++) cycle(0, 0, 1, k2[i]);
        check("b2b_key_hold_last", 64'(key_out), 64'hA5C3_0F96);
        if (PAR) cycle(0, 0, 1, ^k2);
        cycle(0, 0, 0, 0);
        check("b2b_new_key", 64'(key_out), 64'h1234_5678);
        check("b2b_applied", 64'(key_applied), 64'h1);

`ifdef KEY_PARITY_EN
        load(32'h0000_0001, 0, -1, -1, 0);
        check("par_good_key", 64'(key_out), 64'h1);
        check("par_good_applied", 64'(key_applied), 64'h1);
        load(32'h0000_0001, 0, -1, -1, 1);
        check("par_bad_err", 64'(err), 64'h1);
        check("par_bad_key", 64'(key_out), 64'h1);
        check("par_bad_applied", 64'(key_applied), 64'h0);
`endif

        // randomized traffic: dense valids, then sparse valids to provoke timeouts
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(7, 0) == 0, $urandom_range(59, 0) == 0,
                  $urandom_range(2, 0) != 0, 1'($urandom_range(1, 0)));
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(5, 0) == 0, $urandom_range(79, 0) == 0,
                  $urandom_range(7, 0) == 0, 1'($urandom_range(1, 0)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
